// File: rtl/sdram_port_arbiter_if.sv
// Two-master SDRAM command port bundle: request/grant side plus SDRAM side.
// oGntCnt0/oGntCnt1 exist only when ARB_STATS_EN is defined.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 8
);
  logic              iReq0;
  logic              iReq1;
  logic              iWr0;
  logic              iWr1;
  logic [ADDR_W-1:0] iAddr0;
  logic [ADDR_W-1:0] iAddr1;
  logic [DATA_W-1:0] iWdata0;
  logic [DATA_W-1:0] iWdata1;
  logic              oGnt0;
  logic              oGnt1;
  logic              oRdValid0;
  logic              oRdValid1;
  logic [DATA_W-1:0] oRdData;
  logic              oSdramRd;
  logic              oSdramWr;
  logic [ADDR_W-1:0] oSdramAddr;
  logic [DATA_W-1:0] oSdramWdata;
  logic              iSdramWait;
  logic [DATA_W-1:0] iSdramRdData;
  logic              iSdramRdValid;
  logic              oErr;
`ifdef ARB_STATS_EN
  logic [15:0]       oGntCnt0;
  logic [15:0]       oGntCnt1;
`endif

  modport slave (
    input  iReq0, iReq1, iWr0, iWr1,
    input  iAddr0, iAddr1, iWdata0, iWdata1,
    input  iSdramWait, iSdramRdData, iSdramRdValid,
    output oGnt0, oGnt1, oRdValid0, oRdValid1, oRdData,
    output oSdramRd, oSdramWr, oSdramAddr, oSdramWdata,
    output oErr
`ifdef ARB_STATS_EN
    , output oGntCnt0, oGntCnt1
`endif
  );

  modport master (
    output iReq0, iReq1, iWr0, iWr1,
    output iAddr0, iAddr1, iWdata0, iWdata1,
    output iSdramWait, iSdramRdData, iSdramRdValid,
    input  oGnt0, oGnt1, oRdValid0, oRdValid1, oRdData,
    input  oSdramRd, oSdramWr, oSdramAddr, oSdramWdata,
    input  oErr
`ifdef ARB_STATS_EN
    , input oGntCnt0, oGntCnt1
`endif
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-master SDRAM command port arbiter with burst locking and read tag FIFO.
// ARB_STATS_EN adds saturating per-master grant counters.
module sdram_port_arbiter #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int TAG_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_port_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state, stateNxt;
  logic [BW-1:0] burst, burstNxt, base;
  logic cmdRd, cmdWr;
  logic [ADDR_W-1:0] cmdAddr;
  logic [DATA_W-1:0] cmdWdata;
  logic [TAG_DEPTH-1:0] tagMem;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] tagCnt;
  logic rdV0, rdV1, err;
  logic [DATA_W-1:0] rdData;

  logic slotFree, tagFull, atMax;
  logic ok0, ok1, rdBlk0, rdBlk1, wOk0, wOk1;
  logic gnt0, gnt1, gnt, gWr, push, pop;
  logic [ADDR_W-1:0] gAddr;
  logic [DATA_W-1:0] gWdata;

  assign slotFree = !(cmdRd || cmdWr) || !bus.iSdramWait;
  assign tagFull  = tagCnt == CW'(TAG_DEPTH);
  assign atMax    = burst == BW'(MAX_BURST);
  assign ok0      = bus.iReq0 && slotFree && (bus.iWr0 || !tagFull);
  assign ok1      = bus.iReq1 && slotFree && (bus.iWr1 || !tagFull);
  assign rdBlk0   = bus.iReq0 && slotFree && !bus.iWr0 && tagFull;
  assign rdBlk1   = bus.iReq1 && slotFree && !bus.iWr1 && tagFull;
  assign wOk0     = bus.iReq0 && bus.iWr0 && slotFree;
  assign wOk1     = bus.iReq1 && bus.iWr1 && slotFree;

  // Ownership decided first; the new owner is granted in the same cycle.
  always_comb begin
    stateNxt = state;
    base     = burst;
    burstNxt = burst;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    unique case (state)
      IDLE: begin
        base = '0;
        if (bus.iReq0)      stateNxt = OWN0;
        else if (bus.iReq1) stateNxt = OWN1;
      end
      OWN0: begin
        if (bus.iReq1 && (!bus.iReq0 || atMax)) begin
          stateNxt = OWN1;
          base     = '0;
        end else if (!bus.iReq0) begin
          stateNxt = IDLE;
          base     = '0;
        end else if (atMax) begin
          base = '0;
        end
      end
      OWN1: begin
        if (bus.iReq0 && (!bus.iReq1 || atMax)) begin
          stateNxt = OWN0;
          base     = '0;
        end else if (!bus.iReq1) begin
          stateNxt = IDLE;
          base     = '0;
        end else if (atMax) begin
          base = '0;
        end
      end
      default: begin
        stateNxt = IDLE;
        base     = '0;
      end
    endcase
    burstNxt = base;
    unique case (stateNxt)
      OWN0: begin
        if (ok0) begin
          gnt0     = 1'b1;
          burstNxt = base + BW'(1);
        end else if (rdBlk0 && wOk1) begin
          gnt1 = 1'b1;
        end
      end
      OWN1: begin
        if (ok1) begin
          gnt1     = 1'b1;
          burstNxt = base + BW'(1);
        end else if (rdBlk1 && wOk0) begin
          gnt0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gnt    = gnt0 || gnt1;
  assign gWr    = gnt1 ? bus.iWr1    : bus.iWr0;
  assign gAddr  = gnt1 ? bus.iAddr1  : bus.iAddr0;
  assign gWdata = gnt1 ? bus.iWdata1 : bus.iWdata0;
  assign push   = gnt && !gWr;
  assign pop    = bus.iSdramRdValid && (tagCnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      burst <= '0;
    end else begin
      state <= stateNxt;
      burst <= burstNxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmdRd    <= 1'b0;
      cmdWr    <= 1'b0;
      cmdAddr  <= '0;
      cmdWdata <= '0;
    end else if (gnt) begin
      cmdRd    <= !gWr;
      cmdWr    <= gWr;
      cmdAddr  <= gAddr;
      cmdWdata <= gWdata;
    end else if (slotFree) begin
      cmdRd <= 1'b0;
      cmdWr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagMem <= '0;
      wrPtr  <= '0;
      rdPtr  <= '0;
      tagCnt <= '0;
      rdV0   <= 1'b0;
      rdV1   <= 1'b0;
      rdData <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        tagMem[wrPtr] <= gnt1;
        wrPtr         <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr  <= rdPtr + PW'(1);
        rdData <= bus.iSdramRdData;
      end
      unique case ({push, pop})
        2'b10:   tagCnt <= tagCnt + CW'(1);
        2'b01:   tagCnt <= tagCnt - CW'(1);
        default: ;
      endcase
      rdV0 <= pop && !tagMem[rdPtr];
      rdV1 <= pop && tagMem[rdPtr];
      err  <= err || (bus.iSdramRdValid && tagCnt == '0);
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] cnt0, cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (gnt0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
      if (gnt1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
    end
  end

  assign bus.oGntCnt0 = cnt0;
  assign bus.oGntCnt1 = cnt1;
`endif

  assign bus.oGnt0       = gnt0;
  assign bus.oGnt1       = gnt1;
  assign bus.oSdramRd    = cmdRd;
  assign bus.oSdramWr    = cmdWr;
  assign bus.oSdramAddr  = cmdAddr;
  assign bus.oSdramWdata = cmdWdata;
  assign bus.oRdValid0   = rdV0;
  assign bus.oRdValid1   = rdV1;
  assign bus.oRdData     = rdData;
  assign bus.oErr        = err;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized and directed bench for sdram_port_arbiter against a cycle model.
// The grant counter checks run only when ARB_STATS_EN is defined.
module tb_sdram_port_arbiter;
  localparam int AW   = 23;
  localparam int DW   = 8;
  localparam int MAXB = 16;
  localparam int TD   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: committed outputs plus owner/burst/tag queue
  bit mRd, mWr, mV0, mV1, mErr;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWd, mData;
  int owner, burst, mCnt0, mCnt1;
  int tags[$];
  bit nRd, nWr, nV0, nV1, nErr, popF;
  logic [AW-1:0] nAddr;
  logic [DW-1:0] nWd, nData;
  int nOwner, nBurst, pushT, eG, dutG;

  task automatic modelReset();
    mRd = 0; mWr = 0; mV0 = 0; mV1 = 0; mErr = 0;
    mAddr = '0; mWd = '0; mData = '0;
    owner = -1; burst = 0; mCnt0 = 0; mCnt1 = 0;
    tags.delete();
  endtask

  task automatic modelEval();
    bit rq[2], wr[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    bit slot, full;
    int o, b;
    rq[0] = bus.iReq0; rq[1] = bus.iReq1;
    wr[0] = bus.iWr0;  wr[1] = bus.iWr1;
    ad[0] = bus.iAddr0; ad[1] = bus.iAddr1;
    wd[0] = bus.iWdata0; wd[1] = bus.iWdata1;
    slot = !(mRd || mWr) || !bus.iSdramWait;
    full = tags.size() >= TD;
    o = owner; b = burst;
    if (!rq[0] && !rq[1]) begin o = -1; b = 0; end
    else if (o < 0) begin o = rq[0] ? 0 : 1; b = 0; end
    else if (rq[1-o] && (!rq[o] || b == MAXB)) begin o = 1 - o; b = 0; end
    else if (b == MAXB) b = 0;
    eG = -1;
    if (o >= 0 && rq[o] && slot && (wr[o] || !full)) begin
      eG = o; b++;
    end else if (o >= 0 && rq[o] && slot && full && !wr[o] &&
                 rq[1-o] && wr[1-o]) begin
      eG = 1 - o;
    end
    nOwner = o; nBurst = b;
    nRd = mRd; nWr = mWr; nAddr = mAddr; nWd = mWd;
    pushT = -1;
    if (eG >= 0) begin
      nRd = !wr[eG]; nWr = wr[eG]; nAddr = ad[eG]; nWd = wd[eG];
      if (!wr[eG]) pushT = eG;
    end else if (slot) begin
      nRd = 0; nWr = 0;
    end
    popF = bus.iSdramRdValid && tags.size() > 0;
    nV0 = popF && tags[0] == 0;
    nV1 = popF && tags[0] == 1;
    nData = popF ? bus.iSdramRdData : mData;
    nErr = mErr || (bus.iSdramRdValid && tags.size() == 0);
  endtask

  task automatic modelCommit();
    mRd = nRd; mWr = nWr; mAddr = nAddr; mWd = nWd;
    mV0 = nV0; mV1 = nV1; mData = nData; mErr = nErr;
    owner = nOwner; burst = nBurst;
    if (popF) void'(tags.pop_front());
    if (pushT >= 0) tags.push_back(pushT);
    if (eG == 0 && mCnt0 < 65535) mCnt0++;
    if (eG == 1 && mCnt1 < 65535) mCnt1++;
  endtask

  // One clock: inputs already driven at posedge+1; checks mid-cycle
  task automatic step();
    #4;
    modelEval();
    dutG = bus.oGnt0 ? 0 : (bus.oGnt1 ? 1 : -1);
    chk("gnt0", bus.oGnt0, eG == 0);
    chk("gnt1", bus.oGnt1, eG == 1);
    chk("sdRd", bus.oSdramRd, mRd);
    chk("sdWr", bus.oSdramWr, mWr);
    chk("sdAddr", bus.oSdramAddr, mAddr);
    chk("sdWdata", bus.oSdramWdata, mWd);
    chk("rdV0", bus.oRdValid0, mV0);
    chk("rdV1", bus.oRdValid1, mV1);
    chk("rdData", bus.oRdData, mData);
    chk("err", bus.oErr, mErr);
`ifdef ARB_STATS_EN
    chk("cnt0", bus.oGntCnt0, mCnt0);
    chk("cnt1", bus.oGntCnt1, mCnt1);
`endif
    @(posedge clk);
    #1;
    modelCommit();
  endtask

  task automatic clearInputs();
    bus.iReq0 = 0; bus.iReq1 = 0; bus.iWr0 = 0; bus.iWr1 = 0;
    bus.iAddr0 = '0; bus.iAddr1 = '0;
    bus.iWdata0 = '0; bus.iWdata1 = '0;
    bus.iSdramWait = 0; bus.iSdramRdData = '0; bus.iSdramRdValid = 0;
  endtask

  task automatic setReq(input int m, input bit r, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      bus.iReq0 = r; bus.iWr0 = w; bus.iAddr0 = a; bus.iWdata0 = d;
    end else begin
      bus.iReq1 = r; bus.iWr1 = w; bus.iAddr1 = a; bus.iWdata1 = d;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    #1;
    chk("rst_gnt", {bus.oGnt1, bus.oGnt0}, 0);
    chk("rst_cmd", {bus.oSdramRd, bus.oSdramWr}, 0);
    chk("rst_addr", bus.oSdramAddr, 0);
    chk("rst_wdata", bus.oSdramWdata, 0);
    chk("rst_rdv", {bus.oRdValid1, bus.oRdValid0}, 0);
    chk("rst_rddata", bus.oRdData, 0);
    chk("rst_err", bus.oErr, 0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    clearInputs();
    modelReset();
    @(posedge clk);
    #1;
    doReset();

    // Reset mid-burst with three reads outstanding
    for (int i = 0; i < 3; i++) begin
      setReq(0, 1, 0, AW'(i + 1), '0);
      step();
      chk("mid_gnt", dutG, 0);
    end
    clearInputs();
    step();
    doReset();
    setReq(0, 1, 0, 23'h10, '0);
    step();
    chk("mid_rd_gnt", dutG, 0);
    clearInputs();
    step();
    bus.iSdramRdValid = 1;
    bus.iSdramRdData = 8'h55;
    step();
    chk("mid_rdv0", bus.oRdValid0, 1);
    chk("mid_rddata", bus.oRdData, 8'h55);
    clearInputs();
    step();
    chk("mid_rdv0_once", bus.oRdValid0, 0);

    // Tie and burst fairness: both masters hold reads
    doReset();
    begin
      int gq[$];
      for (int c = 0; c < 70; c++) begin
        setReq(0, 1, 0, AW'($urandom), '0);
        setReq(1, 1, 0, AW'($urandom), '0);
        bus.iSdramRdValid = tags.size() > 0;
        bus.iSdramRdData = DW'($urandom);
        step();
        if (dutG >= 0) gq.push_back(dutG);
      end
      chk("fair_cnt", gq.size() >= 64, 1);
      for (int i = 0; i < 64 && i < gq.size(); i++)
        chk("fair_seq", gq[i], (i / 16) % 2);
    end

    // Stall hold on a master 1 write
    doReset();
    setReq(1, 1, 1, 23'h12C0, 8'h7F);
    step();
    chk("stall_gnt", dutG, 1);
    setReq(1, 1, 1, 23'h0AAA, 8'h11);
    bus.iSdramWait = 1;
    for (int i = 0; i < 6; i++) begin
      chk("stall_wr", bus.oSdramWr, 1);
      chk("stall_addr", bus.oSdramAddr, 23'h12C0);
      chk("stall_data", bus.oSdramWdata, 8'h7F);
      if (i == 5) bus.iSdramWait = 0;
      step();
      chk("stall_gnt_hold", dutG, (i == 5) ? 1 : -1);
    end
    chk("stall_next_addr", bus.oSdramAddr, 23'h0AAA);
    clearInputs();
    step();

    // Tag FIFO full
    doReset();
    setReq(1, 1, 0, 23'h200, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("full_rd", dutG, 1);
    end
    step();
    chk("full_block", dutG, -1);
    setReq(0, 1, 1, 23'h300, 8'h5A);
    step();
    chk("full_w0", dutG, 0);
    setReq(0, 0, 0, '0, '0);
    bus.iSdramRdValid = 1;
    bus.iSdramRdData = 8'hA3;
    step();
    chk("full_pop_block", dutG, -1);
    chk("full_rdv1", bus.oRdValid1, 1);
    chk("full_rddata", bus.oRdData, 8'hA3);
    bus.iSdramRdValid = 0;
    step();
    chk("full_regnt", dutG, 1);
    clearInputs();
    step();

    // Interleaved return routing
    doReset();
    begin
      int ord[4] = '{0, 1, 1, 0};
      for (int i = 0; i < 4; i++) begin
        clearInputs();
        setReq(ord[i], 1, 0, AW'(i), '0);
        step();
        chk("il_gnt", dutG, ord[i]);
      end
      clearInputs();
      for (int i = 0; i < 4; i++) begin
        bus.iSdramRdValid = 1;
        bus.iSdramRdData = DW'(i + 1);
        step();
        chk("il_rdv0", bus.oRdValid0, ord[i] == 0);
        chk("il_rdv1", bus.oRdValid1, ord[i] == 1);
        chk("il_data", bus.oRdData, i + 1);
      end
      clearInputs();
      step();
    end

    // Stray return
    doReset();
    bus.iSdramRdValid = 1;
    bus.iSdramRdData = 8'h99;
    step();
    chk("stray_err", bus.oErr, 1);
    chk("stray_rdv", {bus.oRdValid1, bus.oRdValid0}, 0);
    bus.iSdramRdValid = 0;
    repeat (3) step();
    chk("stray_sticky", bus.oErr, 1);

`ifdef ARB_STATS_EN
    doReset();
    setReq(0, 1, 1, 23'h1, 8'h1);
    repeat (70000) @(posedge clk);
    #1;
    chk("stat_sat0", bus.oGntCnt0, 16'hFFFF);
    chk("stat_cnt1", bus.oGntCnt1, 0);
`endif

    // Randomized traffic, with one reset in the middle
    doReset();
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) doReset();
      for (int m = 0; m < 2; m++) begin
        bit r;
        r = (m == 0) ? bus.iReq0 : bus.iReq1;
        if (eG == m || !r) begin
          if ($urandom_range(99) < 55)
            setReq(m, 1, $urandom_range(1), AW'($urandom), DW'($urandom));
          else
            setReq(m, 0, 0, '0, '0);
        end
      end
      bus.iSdramWait = $urandom_range(3) == 0;
      bus.iSdramRdValid = tags.size() > 0 && $urandom_range(2) == 0;
      bus.iSdramRdData = DW'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
